velocity_cell_pingpong: RTL and testbench
=========================================

Name: velocity_cell_pingpong

Overview:
Parametrised successor to the per-cell velocity RAMs. It holds two banks of per-particle velocity words {vz, vy, vx} for one cell, in ping-pong arrangement. The read bank serves the motion-update / force pipeline for the current timestep, while the write bank collects updated or migrated particle velocities for the next timestep. Particle counts live in dedicated registers, not at address 0, and a swap command exchanges the banks between timesteps.

Parameters:
DATA_WIDTH, 96, velocity word width, {vz, vy, vx}, 32 bits each.
PARTICLE_NUM, 220, depth of each bank, in particles; must be ≤ 2**ADDR_WIDTH.
ADDR_WIDTH, 8, particle index width.
READ_LATENCY, 1, read latency in cycles; legal values 1 (registered RAM output) or 2 (extra output register).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  read request; accepted only when rd_ready=1
rd_addr  in  ADDR_WIDTH  particle index in the read bank
rd_ready  out  1  low while a swap is pending or executing
rd_valid  out  1  read data valid, READ_LATENCY cycles after acceptance
rd_data  out  DATA_WIDTH  velocity word; zero when rd_oob=1
rd_oob  out  1  qualifies rd_valid: rd_addr ≥ rd_count at acceptance
wr_en  in  1  append one particle to the write bank
wr_data  in  DATA_WIDTH  velocity word to append
wr_full  out  1  wr_count == PARTICLE_NUM
wr_overflow  out  1  sticky: an append was dropped; cleared by swap
swap_req  in  1  single-cycle request to exchange banks
swap_busy  out  1  swap pending
swap_done  out  1  one-cycle pulse on the cycle the swap commits
bank_sel  out  1  index of the current read bank
rd_count  out  ADDR_WIDTH+1  particles in the read bank
wr_count  out  ADDR_WIDTH+1  particles in the write bank

Behaviour:
- Reset (asynchronous, rst_n=0): bank_sel=0, rd_count=0, wr_count=0, rd_valid=0, rd_oob=0, rd_data=0, wr_overflow=0, swap_busy=0, swap_done=0, rd_ready=1, read pipeline flushed. RAM contents are not reset; because rd_count=0, every read returns oob with zero data. Reset mid-swap or mid-read abandons the operation with no pending effects.
- Storage: two DATA_WIDTH×PARTICLE_NUM single-port-per-bank RAMs. The read bank is bank_sel and the write bank is ~bank_sel, so there is no read/write contention.
- Read: accepted when rd_en & rd_ready. rd_valid is asserted exactly READ_LATENCY cycles later, with the matching rd_oob. Back-to-back reads every cycle are supported. Out-of-bounds reads do not access RAM content; they return rd_data=0.
- Write: when wr_en=1 and wr_full=0, write wr_data to address wr_count and increment wr_count. When wr_en=1 and wr_full=1, drop the data, set wr_overflow, and leave wr_count unchanged. The write address never wraps.
- Swap FSM, states IDLE → DRAIN → COMMIT → IDLE:
  - IDLE: swap_req → DRAIN, swap_busy=1, rd_ready=0. A read accepted in the same cycle as swap_req is still honoured.
  - DRAIN: wait until no read is in flight in the read pipeline, then go to COMMIT.
  - COMMIT, one cycle: toggle bank_sel; rd_count ← wr_count, including any append accepted in this cycle; wr_count ← 0; wr_overflow ← 0; swap_done=1. Next state IDLE, with swap_busy=0 and rd_ready=1 from the following cycle.
  - swap_req while swap_busy=1 is ignored.
- Writes are legal in every state. A write in the COMMIT cycle lands in the old write bank and is counted in the new rd_count.
- Minimum swap-to-done latency: 2 cycles when nothing is in flight; READ_LATENCY+2 worst case.

Test Plan:
- Reset, then read addr 0 → rd_valid after READ_LATENCY cycles, rd_oob=1, rd_data=0, rd_count=0.
- Append 3 words A, B, C; swap; read addrs 0, 1, 2, 3 back-to-back → A, B, C, then oob with zero data. swap_done pulses once; bank_sel=1; rd_count=3; wr_count=0.
- Append 220 words, then a 221st → wr_full=1, wr_overflow=1, wr_count=220. A following swap clears wr_overflow and gives rd_count=220.
- swap_req in the same cycle as rd_en, with READ_LATENCY=2 → that read returns old-bank data. rd_ready stays low until swap_done. Reads attempted while busy produce no rd_valid.
- wr_en asserted in the COMMIT cycle after 5 prior appends → new rd_count=6, and the 6th word is readable at addr 5.
- Assert rst_n=0 mid-DRAIN → all outputs at reset values immediately, bank_sel=0, no swap_done pulse.

Source files
------------

// File: rtl/velocity_cell_pingpong_if.sv
// Bus bundle for the ping-pong velocity store: read port, append port,
// swap handshake and the occupancy/status outputs.
interface velocity_cell_pingpong_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_oob;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  wr_overflow;
    logic                  swap_req;
    logic                  swap_busy;
    logic                  swap_done;
    logic                  bank_sel;
    logic [ADDR_WIDTH:0]   rd_count;
    logic [ADDR_WIDTH:0]   wr_count;

    modport master (
        output rd_en, rd_addr, wr_en, wr_data, swap_req,
        input  rd_ready, rd_valid, rd_data, rd_oob, wr_full, wr_overflow,
               swap_busy, swap_done, bank_sel, rd_count, wr_count
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_data, swap_req,
        output rd_ready, rd_valid, rd_data, rd_oob, wr_full, wr_overflow,
               swap_busy, swap_done, bank_sel, rd_count, wr_count
    );
endinterface

// File: rtl/velocity_cell_pingpong.sv
// Two-bank ping-pong store of per-particle velocity words {vz, vy, vx}.
// The read bank feeds the current timestep; the write bank collects the
// next one; a swap exchanges them once the read pipeline is empty.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | normal operation, reads accepted, swap_req starts a swap
// DRAIN  | reads blocked, waiting for in-flight reads to retire
// COMMIT | one cycle: flip banks, move wr_count into rd_count
module velocity_cell_pingpong #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    velocity_cell_pingpong_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] C_FULL = (ADDR_WIDTH + 1)'(PARTICLE_NUM);
    localparam logic [ADDR_WIDTH:0] C_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT} state_t;

    logic [DATA_WIDTH-1:0] r_mem0 [PARTICLE_NUM];
    logic [DATA_WIDTH-1:0] r_mem1 [PARTICLE_NUM];

    state_t                r_state;
    logic                  r_bank_sel;
    logic                  r_swap_busy;
    logic                  r_swap_done;
    logic                  r_rd_ready;
    logic                  r_wr_overflow;
    logic [ADDR_WIDTH:0]   r_rd_count;
    logic [ADDR_WIDTH:0]   r_wr_count;

    logic                  r_v1;
    logic                  r_oob1;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_v2;
    logic                  r_oob2;
    logic [DATA_WIDTH-1:0] r_d2;

    logic w_rd_accept;
    logic w_rd_oob;
    logic w_wr_full;
    logic w_wr_accept;
    logic w_inflight;

    assign w_rd_accept = bus.rd_en & r_rd_ready;
    assign w_rd_oob    = ({1'b0, bus.rd_addr} >= r_rd_count);
    assign w_wr_full   = (r_wr_count == C_FULL);
    assign w_wr_accept = bus.wr_en & ~w_wr_full;
    // The second stage only exists in the pipeline when latency is 2.
    assign w_inflight  = (READ_LATENCY == 2) ? (r_v1 | r_v2) : r_v1;

    // Append into the bank that is not being read; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            if (r_bank_sel)
                r_mem0[r_wr_count[ADDR_WIDTH-1:0]] <= bus.wr_data;
            else
                r_mem1[r_wr_count[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    // First read stage: registered RAM output, forced to zero out of bounds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_oob1 <= 1'b0;
            r_d1   <= '0;
        end else begin
            r_v1   <= w_rd_accept;
            r_oob1 <= w_rd_accept & w_rd_oob;
            if (w_rd_accept) begin
                if (w_rd_oob)
                    r_d1 <= '0;
                else if (r_bank_sel)
                    r_d1 <= r_mem1[bus.rd_addr];
                else
                    r_d1 <= r_mem0[bus.rd_addr];
            end
        end
    end

    // Optional second read stage, selected when READ_LATENCY is 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_oob2 <= 1'b0;
            r_d2   <= '0;
        end else begin
            r_v2   <= r_v1;
            r_oob2 <= r_oob1;
            if (r_v1)
                r_d2 <= r_d1;
        end
    end

    // Swap sequencer together with the counters and flags it commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bank_sel    <= 1'b0;
            r_swap_busy   <= 1'b0;
            r_swap_done   <= 1'b0;
            r_rd_ready    <= 1'b1;
            r_wr_overflow <= 1'b0;
            r_rd_count    <= '0;
            r_wr_count    <= '0;
        end else begin
            r_swap_done <= 1'b0;
            if (w_wr_accept)
                r_wr_count <= r_wr_count + C_ONE;
            else if (bus.wr_en)
                r_wr_overflow <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.swap_req) begin
                        r_state     <= S_DRAIN;
                        r_swap_busy <= 1'b1;
                        r_rd_ready  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!w_inflight) begin
                        r_state     <= S_COMMIT;
                        r_swap_done <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    // An append landing this cycle belongs to the new read bank.
                    r_state       <= S_IDLE;
                    r_bank_sel    <= ~r_bank_sel;
                    r_rd_count    <= r_wr_count + {{ADDR_WIDTH{1'b0}}, w_wr_accept};
                    r_wr_count    <= '0;
                    r_wr_overflow <= 1'b0;
                    r_swap_busy   <= 1'b0;
                    r_rd_ready    <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_ready    = r_rd_ready;
    assign bus.rd_valid    = (READ_LATENCY == 2) ? r_v2   : r_v1;
    assign bus.rd_oob      = (READ_LATENCY == 2) ? r_oob2 : r_oob1;
    assign bus.rd_data     = (READ_LATENCY == 2) ? r_d2   : r_d1;
    assign bus.wr_full     = w_wr_full;
    assign bus.wr_overflow = r_wr_overflow;
    assign bus.swap_busy   = r_swap_busy;
    assign bus.swap_done   = r_swap_done;
    assign bus.bank_sel    = r_bank_sel;
    assign bus.rd_count    = r_rd_count;
    assign bus.wr_count    = r_wr_count;

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Bench for velocity_cell_pingpong (READ_LATENCY=2): table-driven reads,
// a reference model of both banks, and a read scoreboard.
module tb_velocity_cell_pingpong;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int RL = 2;

    localparam logic [DW-1:0] WA = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    localparam logic [DW-1:0] WB = {32'hBF80_0000, 32'hC000_0000, 32'hC040_0000};
    localparam logic [DW-1:0] WC = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
    localparam logic [DW-1:0] WX = {32'hDEAD_BEEF, 32'h0000_0001, 32'h7777_0000};
    localparam logic [DW-1:0] WY = {32'hCAFE_F00D, 32'h0000_0002, 32'h8888_0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    velocity_cell_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    velocity_cell_pingpong #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          oob;
        int            vcyc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          oob;
        logic [DW-1:0] data;
    } rvec_t;

    exp_t  q[$];
    exp_t  me;
    exp_t  te;
    rvec_t tbl[4];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;

    logic [DW-1:0] m_mem [2][256];
    int            m_rd_count;
    int            m_wr_count;
    logic          m_sel;
    logic          m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] vword(input int i);
        return {32'(i) ^ 32'hA5A5_0000, 32'(i * 3), 32'(i) + 32'h0000_1000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        exp_t e;
        e.oob  = (int'(a) >= m_rd_count);
        e.data = e.oob ? '0 : m_mem[m_sel][a];
        e.vcyc = cyc + RL;
        q.push_back(e);
    endtask

    task automatic read1(input logic [AW-1:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        push_read(a);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic model_append(input logic [DW-1:0] w);
        if (m_wr_count < PN) begin
            m_mem[!m_sel][m_wr_count[7:0]] = w;
            m_wr_count++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic append(input logic [DW-1:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        model_append(w);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("read_drain_pending", q.size(), 0);
        q.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_rd_oob", int'(bus.rd_oob), 0);
        chk_d("rst_rd_data", bus.rd_data, '0);
        chk("rst_bank_sel", int'(bus.bank_sel), 0);
        chk("rst_rd_count", int'(bus.rd_count), 0);
        chk("rst_wr_count", int'(bus.wr_count), 0);
        chk("rst_wr_overflow", int'(bus.wr_overflow), 0);
        chk("rst_swap_busy", int'(bus.swap_busy), 0);
        chk("rst_swap_done", int'(bus.swap_done), 0);
        chk("rst_rd_ready", int'(bus.rd_ready), 1);
        chk("rst_wr_full", int'(bus.wr_full), 0);
    endtask

    // rd_same: read issued alongside swap_req; rd_busy: keep rd_en high
    // while busy; wr_commit: append cw during the COMMIT cycle.
    task automatic do_swap(input bit rd_same, input logic [AW-1:0] ra,
                           input bit rd_busy, input bit wr_commit,
                           input logic [DW-1:0] cw);
        int start;
        bit seen;
        seen  = 1'b0;
        start = cyc;
        bus.swap_req = 1'b1;
        if (rd_same) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = ra;
            push_read(ra);
        end
        tick();
        bus.swap_req = 1'b0;
        bus.rd_en    = rd_busy;
        for (int i = 0; i < 16; i++) begin
            if (bus.swap_done) begin
                seen = 1'b1;
                break;
            end
            chk("busy_rd_ready", int'(bus.rd_ready), 0);
            chk("busy_swap_busy", int'(bus.swap_busy), 1);
            tick();
        end
        chk("swap_done_seen", int'(seen), 1);
        chk("swap_latency", cyc - start, rd_same ? RL + 2 : 2);
        chk("commit_rd_ready", int'(bus.rd_ready), 0);
        bus.rd_en = 1'b0;
        if (wr_commit) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = cw;
            model_append(cw);
        end
        tick();
        bus.wr_en = 1'b0;
        m_sel      = ~m_sel;
        m_rd_count = m_wr_count;
        m_wr_count = 0;
        m_ovf      = 1'b0;
        chk("post_swap_done", int'(bus.swap_done), 0);
        chk("post_swap_busy", int'(bus.swap_busy), 0);
        chk("post_swap_rd_ready", int'(bus.rd_ready), 1);
        chk("post_swap_bank_sel", int'(bus.bank_sel), int'(m_sel));
        chk("post_swap_rd_count", int'(bus.rd_count), m_rd_count);
        chk("post_swap_wr_count", int'(bus.wr_count), 0);
        chk("post_swap_overflow", int'(bus.wr_overflow), 0);
    endtask

    // Scoreboard: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n && bus.swap_done) n_done++;
        if (rst_n && bus.rd_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rd_valid", int'(bus.rd_valid), 0);
            end else begin
                me = q.pop_front();
                chk_d("rd_data", bus.rd_data, me.data);
                chk("rd_oob", int'(bus.rd_oob), int'(me.oob));
                chk("rd_latency", cyc, me.vcyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        m_sel        = 1'b0;
        m_ovf        = 1'b0;
        m_rd_count   = 0;
        m_wr_count   = 0;

        tbl[0] = '{addr: 8'd0, oob: 1'b0, data: WA};
        tbl[1] = '{addr: 8'd1, oob: 1'b0, data: WB};
        tbl[2] = '{addr: 8'd2, oob: 1'b0, data: WC};
        tbl[3] = '{addr: 8'd3, oob: 1'b1, data: '0};

        // Reset values, then a read from the empty bank.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        tick();
        read1(8'd0);
        chk("empty_rd_count", int'(bus.rd_count), 0);
        wait_drain();

        // Three appends, swap, back-to-back table reads.
        append(WA);
        append(WB);
        append(WC);
        chk("abc_wr_count", int'(bus.wr_count), 3);
        do_swap(1'b0, '0, 1'b0, 1'b0, '0);
        chk("abc_bank_sel", int'(bus.bank_sel), 1);
        chk("abc_rd_count", int'(bus.rd_count), 3);
        chk("abc_wr_count_zero", int'(bus.wr_count), 0);
        for (int i = 0; i < 4; i++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = tbl[i].addr;
            te.data = tbl[i].data;
            te.oob  = tbl[i].oob;
            te.vcyc = cyc + RL;
            q.push_back(te);
            tick();
        end
        bus.rd_en = 1'b0;
        wait_drain();

        // Fill to capacity, overflow, then swap clears the flag.
        for (int i = 0; i < PN; i++) append(vword(i));
        chk("fill_wr_full", int'(bus.wr_full), 1);
        chk("fill_overflow_before", int'(bus.wr_overflow), 0);
        chk("fill_wr_count", int'(bus.wr_count), 220);
        append(vword(999));
        chk("ovf_wr_full", int'(bus.wr_full), 1);
        chk("ovf_overflow", int'(bus.wr_overflow), 1);
        chk("ovf_wr_count", int'(bus.wr_count), 220);
        do_swap(1'b0, '0, 1'b0, 1'b0, '0);
        chk("fill_rd_count", int'(bus.rd_count), 220);
        chk("fill_overflow_cleared", int'(bus.wr_overflow), 0);
        read1(8'd0);
        read1(8'd219);
        read1(8'd220);
        read1(8'd255);
        wait_drain();

        // Read in the swap_req cycle returns old-bank data; busy reads are ignored.
        append(WX);
        append(WY);
        do_swap(1'b1, 8'd7, 1'b1, 1'b0, '0);
        chk("rdswap_rd_count", int'(bus.rd_count), 2);
        read1(8'd0);
        read1(8'd1);
        read1(8'd2);
        wait_drain();

        // Append in the COMMIT cycle is counted in the new read bank.
        for (int i = 0; i < 5; i++) append(vword(100 + i));
        do_swap(1'b0, '0, 1'b0, 1'b1, vword(105));
        chk("commit_wr_rd_count", int'(bus.rd_count), 6);
        chk("commit_wr_wr_count", int'(bus.wr_count), 0);
        read1(8'd5);
        read1(8'd4);
        read1(8'd6);
        wait_drain();

        // Reset while in DRAIN abandons the swap and the read.
        for (int i = 0; i < 3; i++) append(vword(200 + i));
        do_swap(1'b0, '0, 1'b0, 1'b0, '0);
        append(WA);
        append(WB);
        chk("pre_rst_bank_sel", int'(bus.bank_sel), 1);
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 8'd0;
        bus.swap_req = 1'b1;
        tick();
        bus.rd_en    = 1'b0;
        bus.swap_req = 1'b0;
        chk("drain_swap_busy", int'(bus.swap_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        q.delete();
        m_sel      = 1'b0;
        m_ovf      = 1'b0;
        m_rd_count = 0;
        m_wr_count = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_swap_done", int'(bus.swap_done), 0);
            chk("post_rst_bank_sel", int'(bus.bank_sel), 0);
        end
        read1(8'd0);
        wait_drain();

        chk("swap_done_pulses", n_done, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
